// File: rtl/mips_datapath_memory_access.sv
// Memory-stage access controller: aligns byte enables and store data into the
// addressed lanes, runs a valid/ready request plus response handshake to the
// data memory, stalls the pipeline until completion and returns the aligned,
// extended load result. Misaligned accesses and bus timeouts are flagged.
module mips_datapath_memory_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [3:0]  byteEnable,
  input  logic        signExtend,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic        done,
  output logic [31:0] readData,
  output logic        misaligned,
  output logic        busError,
  output logic        memValid,
  input  logic        memReady,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [3:0]  memByteEnable,
  output logic [31:0] memWriteData,
  input  logic        memRespValid,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DONE} stateType;

  stateType    state;
  stateType    nextState;
  logic [7:0]  waitCount;
  logic [8:0]  waitCountNext;
  logic        writeReg;
  logic [3:0]  byteEnableReg;
  logic        signExtendReg;
  logic [31:0] addressReg;
  logic [31:0] writeDataReg;
  logic        capture;
  logic        respTaken;
  logic        misalignedNext;
  logic        busErrorNext;
  logic [31:0] loadResult;

  // Only the three defined access sizes reach the bus; any other code is a no-op.
  function automatic logic codeValid(input logic [3:0] code);
    return (code == 4'b0001) || (code == 4'b0011) || (code == 4'b1111);
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic isMisaligned(input logic [3:0] code, input logic [1:0] lane);
    return ((code == 4'b0011) && lane[0]) || ((code == 4'b1111) && (lane != 2'b00));
  endfunction

  // Shift the raw word down to lane 0 and extend the accessed size to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] lane,
                                             input logic [3:0] code, input logic sext);
    logic [31:0] shifted;
    shifted = raw >> {lane, 3'b000};
    case (code)
      4'b0001: return {{24{sext & shifted[7]}}, shifted[7:0]};
      4'b0011: return {{16{sext & shifted[15]}}, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  assign waitCountNext = {1'b0, waitCount} + 9'd1;
  assign loadResult    = extendLoad(memReadData, addressReg[1:0], byteEnableReg, signExtendReg);

  // Request fields come straight from the captured copy so they stay stable.
  assign memValid      = (state == REQUEST);
  assign memWrite      = writeReg;
  assign memAddress    = {addressReg[31:2], 2'b00};
  assign memByteEnable = byteEnableReg << addressReg[1:0];
  assign memWriteData  = writeDataReg << {addressReg[1:0], 3'b000};
  assign done          = (state == DONE);
  assign stall         = !reset && (((state == IDLE) && start) || (state == REQUEST) || (state == WAIT));

  // Next-state decode; a response always wins over a timeout on the same cycle.
  always_comb begin
    nextState      = state;
    capture        = 1'b0;
    respTaken      = 1'b0;
    misalignedNext = 1'b0;
    busErrorNext   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (!codeValid(byteEnable)) begin
            nextState = DONE;
          end else if (isMisaligned(byteEnable, address[1:0])) begin
            nextState      = DONE;
            misalignedNext = 1'b1;
          end else begin
            nextState = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (memReady) begin
          if (memRespValid) begin
            nextState = DONE;
            respTaken = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (memRespValid) begin
          nextState = DONE;
          respTaken = 1'b1;
        end else if (waitCountNext >= 9'(TIMEOUT)) begin
          nextState    = DONE;
          busErrorNext = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register and WAIT cycle counter (cleared whenever not waiting).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCount <= '0;
    end else begin
      state     <= nextState;
      waitCount <= (state == WAIT) ? waitCountNext[7:0] : 8'd0;
    end
  end

  // Capture the memory op when it is accepted out of IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      writeReg      <= 1'b0;
      byteEnableReg <= '0;
      signExtendReg <= 1'b0;
      addressReg    <= '0;
      writeDataReg  <= '0;
    end else if (capture) begin
      writeReg      <= write;
      byteEnableReg <= byteEnable;
      signExtendReg <= signExtend;
      addressReg    <= address;
      writeDataReg  <= writeData;
    end
  end

  // Completion flags and load result, updated on entry to DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misaligned <= 1'b0;
      busError   <= 1'b0;
      readData   <= '0;
    end else begin
      misaligned <= misalignedNext;
      busError   <= busErrorNext;
      if (busErrorNext) begin
        readData <= '0;
      end else if (respTaken && !writeReg) begin
        readData <= loadResult;
      end
    end
  end

endmodule

// File: tb/tb_mips_datapath_memory_access.sv
// Randomised scoreboard bench for mips_datapath_memory_access with a small
// arithmetic reference model for lane placement and load extension.
module tb_mips_datapath_memory_access;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteEnable = '0;
  logic        signExtend = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        stall, done, misaligned, busError, memValid, memWrite;
  logic [31:0] readData, memAddress, memWriteData;
  logic [3:0]  memByteEnable;
  logic        memReady = 1'b0;
  logic        memRespValid = 1'b0;
  logic [31:0] memReadData = '0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        berr;
  } expType;

  expType      expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] lastRead = '0;

  mips_datapath_memory_access #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .write(write),
    .byteEnable(byteEnable), .signExtend(signExtend), .address(address),
    .writeData(writeData), .stall(stall), .done(done), .readData(readData),
    .misaligned(misaligned), .busError(busError), .memValid(memValid),
    .memReady(memReady), .memWrite(memWrite), .memAddress(memAddress),
    .memByteEnable(memByteEnable), .memWriteData(memWriteData),
    .memRespValid(memRespValid), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference load: shift down by whole bytes, keep the access size, extend.
  function automatic logic [31:0] modelLoad(input logic [3:0] be, input bit se,
                                            input int s, input logic [31:0] w);
    longint unsigned x, v, lim;
    int bits;
    x    = {32'd0, w} / (64'd1 << (8 * s));
    bits = (be == 4'b0001) ? 8 : (be == 4'b0011) ? 16 : 32;
    lim  = 64'd1 << bits;
    v    = x % lim;
    if (se && bits < 32 && v >= (lim / 2)) v = v + (64'd1 << 32) - lim;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Issue one op, play the memory side, check the request and completion time.
  task automatic doOp(input bit wr, input logic [3:0] be, input bit se,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdWord, input int readyDly,
                      input int respDly, input bit noResp);
    int s, cat, expCycle, guard;
    longint unsigned expBe, expWd;
    expType e;
    s = int'(addr % 4);
    if (!(be == 4'b0001 || be == 4'b0011 || be == 4'b1111)) cat = 0;
    else if ((be == 4'b0011 && (addr % 2) != 0) || (be == 4'b1111 && s != 0)) cat = 1;
    else cat = 2;
    expBe = ({60'd0, be} * (64'd1 << s)) % 16;
    expWd = ({32'd0, wd} * (64'd1 << (8 * s))) % (64'd1 << 32);
    if (cat == 2) begin
      if (noResp) lastRead = 32'd0;
      else if (!wr) lastRead = modelLoad(be, se, s, rdWord);
    end
    e.rd = lastRead; e.mis = (cat == 1); e.berr = (cat == 2) && noResp;
    expQ.push_back(e);
    expCycle = (cat < 2) ? 1 : (2 + readyDly + (noResp ? TMO : respDly));

    start = 1'b1; write = wr; byteEnable = be; signExtend = se;
    address = addr; writeData = wd;
    cyc = 0;
    #1 chk("stallAtStart", {31'd0, stall}, 32'd1);
    tick();
    start = 1'($urandom % 2); write = 1'($urandom); byteEnable = 4'($urandom);
    signExtend = 1'($urandom); address = $urandom; writeData = $urandom;
    if (cat == 2) begin
      for (int i = 0; i <= readyDly; i++) begin
        chk("memValid", {31'd0, memValid}, 32'd1);
        chk("stallReq", {31'd0, stall}, 32'd1);
        chk("memWrite", {31'd0, memWrite}, {31'd0, wr});
        chk("memAddress", memAddress, addr - (addr % 4));
        chk("memByteEnable", {28'd0, memByteEnable}, expBe[31:0]);
        chk("memWriteData", memWriteData, expWd[31:0]);
        if (i == readyDly) begin
          memReady = 1'b1;
          memRespValid = (!noResp && respDly == 0);
          memReadData = memRespValid ? rdWord : $urandom;
        end else begin
          memReady = 1'b0;
          memRespValid = 1'($urandom);
          memReadData = $urandom;
        end
        tick();
      end
      memReady = 1'b0; memRespValid = 1'b0;
      if (!noResp && respDly > 0) begin
        for (int i = 0; i < respDly - 1; i++) begin
          chk("memValidWait", {31'd0, memValid}, 32'd0);
          memReadData = $urandom;
          tick();
        end
        memRespValid = 1'b1; memReadData = rdWord;
        tick();
        memRespValid = 1'b0;
      end
    end
    guard = 0;
    while (!done && guard < 300) begin
      start = 1'b0;
      tick();
      guard++;
    end
    chk("doneCycle", cyc, expCycle);
    chk("stallInDone", {31'd0, stall}, 32'd0);
    start = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every done pulse must match the next expected result.
  always @(negedge clock) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpectedDone actual=1 required=0");
      end else begin
        expType e;
        e = expQ.pop_front();
        chk("readData", readData, e.rd);
        chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        chk("busError", {31'd0, busError}, {31'd0, e.berr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [5];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b1111; codes[4] = 4'b0101;

    #2;
    chk("rstState", {26'd0, stall, done, misaligned, busError, memValid, memWrite}, 32'd0);
    chk("rstReadData", readData, 32'd0);
    chk("rstMemAddress", memAddress, 32'd0);
    chk("rstMemBe", {28'd0, memByteEnable}, 32'd0);
    chk("rstMemWd", memWriteData, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    tick();

    // Directed cases
    doOp(0, 4'b1111, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    doOp(0, 4'b0001, 1, 32'h1003, 32'h0, 32'h80FF0000, 0, 0, 0);
    doOp(0, 4'b0001, 0, 32'h1003, 32'h0, 32'h80FF0000, 0, 1, 0);
    doOp(1, 4'b0011, 0, 32'h2002, 32'h0000ABCD, 32'h0, 3, 2, 0);
    doOp(0, 4'b1111, 0, 32'h3001, 32'h0, 32'h0, 0, 0, 0);
    doOp(0, 4'b0000, 0, 32'h3000, 32'h0, 32'h0, 0, 0, 0);
    doOp(0, 4'b0011, 1, 32'h4002, 32'h0, 32'h8001_1234, 1, 4, 0);
    doOp(0, 4'b1111, 0, 32'h5000, 32'h0, 32'h0, 0, 0, 1);

    // Reset while the request is pending: memValid and stall drop at once
    start = 1'b1; write = 1'b0; byteEnable = 4'b1111; address = 32'h6000;
    tick();
    start = 1'b0;
    chk("preRstValid", {31'd0, memValid}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rstReqValid", {31'd0, memValid}, 32'd0);
    chk("rstReqStall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Reset while waiting for the response
    start = 1'b1; address = 32'h6004;
    tick();
    start = 1'b0; memReady = 1'b1;
    tick();
    memReady = 1'b0;
    tick();
    chk("preRstStall", {31'd0, stall}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rstWaitStall", {31'd0, stall}, 32'd0);
    chk("rstWaitValid", {31'd0, memValid}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    lastRead = 32'd0;
    memRespValid = 1'b1; memReadData = 32'h12345678;
    tick();
    memRespValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("noDoneAfterRst", {31'd0, done}, 32'd0);
      tick();
    end
    doOp(0, 4'b1111, 0, 32'h7000, 32'h0, 32'hCAFEF00D, 0, 2, 0);

    // Randomised ops
    for (int n = 0; n < 150; n++) begin
      doOp(1'($urandom), codes[$urandom % 5], 1'($urandom), $urandom, $urandom,
           $urandom, int'($urandom % 4), int'($urandom % 5), ($urandom % 10) == 0);
    end

    tick();
    tick();
    chk("queueEmpty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
